// File: rtl/huffman_fixed_pkg.sv
// Shared types and tables for the fixed-Huffman (BTYPE=01) DEFLATE encoder and decoder.
package huffman_fixed_pkg;

  localparam int LIT_DAT_W = 8;
  localparam int LEN_DAT_W = 7;
  localparam int DIS_DAT_W = 7;
  localparam int BUF_W     = 32;

  localparam logic [8:0] EOB_SYM       = 9'd256;
  localparam logic [8:0] LEN_SYM_LAST  = 9'd276;
  localparam logic [4:0] DIS_CODE_LAST = 5'd11;

  // Length symbols 257..276 map to index 0..19; distance codes 0..11.
  localparam logic [6:0] LEN_BASE  [20] = '{7'd3, 7'd4, 7'd5, 7'd6, 7'd7, 7'd8, 7'd9, 7'd10,
                                            7'd11, 7'd13, 7'd15, 7'd17, 7'd19, 7'd23, 7'd27,
                                            7'd31, 7'd35, 7'd43, 7'd51, 7'd59};
  localparam logic [2:0] LEN_XBITS [20] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0,
                                            3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2,
                                            3'd3, 3'd3, 3'd3, 3'd3};
  localparam logic [6:0] DIS_BASE  [12] = '{7'd1, 7'd2, 7'd3, 7'd4, 7'd5, 7'd7, 7'd9, 7'd13,
                                            7'd17, 7'd25, 7'd33, 7'd49};
  localparam logic [2:0] DIS_XBITS [12] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2,
                                            3'd3, 3'd3, 3'd4, 3'd4};

  // state   | meaning
  // ST_HDR  | wait for and parse the 3-bit block header
  // ST_SYM  | decode one literal/length symbol
  // ST_LEXT | add length extra bits
  // ST_DIS  | decode the 5-bit distance code
  // ST_DEXT | add distance extra bits
  // ST_OUT  | present token until downstream takes it
  // ST_DONE | final EOB seen or error; exits only via reset
  typedef enum logic [2:0] {
    ST_HDR, ST_SYM, ST_LEXT, ST_DIS, ST_DEXT, ST_OUT, ST_DONE
  } state_t;

  function automatic logic [6:0] len_base(input logic [4:0] idx);
    return (idx < 5'd20) ? LEN_BASE[idx] : 7'd0;
  endfunction

  function automatic logic [2:0] len_xbits(input logic [4:0] idx);
    return (idx < 5'd20) ? LEN_XBITS[idx] : 3'd0;
  endfunction

  function automatic logic [6:0] dis_base(input logic [3:0] idx);
    return (idx < 4'd12) ? DIS_BASE[idx] : 7'd0;
  endfunction

  function automatic logic [2:0] dis_xbits(input logic [3:0] idx);
    return (idx < 4'd12) ? DIS_XBITS[idx] : 3'd0;
  endfunction

endpackage

// File: rtl/huffman_fixed_dec_if.sv
// Byte-stream input and token output handshakes of the fixed-Huffman decoder.
interface huffman_fixed_dec_if #(
  parameter int LIT_DAT_WD = 8,
  parameter int LEN_DAT_WD = 7,
  parameter int DIS_DAT_WD = 7
);
  logic                  val_i;
  logic [7:0]            dat_i;
  logic                  rdy_o;
  logic                  val_o;
  logic                  rdy_i;
  logic                  flg_lit_o;
  logic [LIT_DAT_WD-1:0] lit_dat_o;
  logic [LEN_DAT_WD-1:0] len_dat_o;
  logic [DIS_DAT_WD-1:0] dis_dat_o;
  logic                  eob_o;
  logic                  final_o;
  logic                  err_o;

  modport slave (
    input  val_i, dat_i, rdy_i,
    output rdy_o, val_o, flg_lit_o, lit_dat_o, len_dat_o, dis_dat_o, eob_o, final_o, err_o
  );

  modport master (
    output val_i, dat_i, rdy_i,
    input  rdy_o, val_o, flg_lit_o, lit_dat_o, len_dat_o, dis_dat_o, eob_o, final_o, err_o
  );
endinterface

// File: rtl/huffman_fixed_sym_dec.sv
// Fixed literal/length code lookup: 9 code bits (first stream bit in MSB) -> symbol and code length.
module huffman_fixed_sym_dec (
  input  logic [8:0] peek_i,
  output logic [8:0] sym_o,
  output logic [3:0] len_o
);
  logic [6:0] p7;
  logic [7:0] p8;

  always_comb begin
    p7    = peek_i[8:2];
    p8    = peek_i[8:1];
    sym_o = '0;
    len_o = '0;
    if (p7 < 7'h18) begin
      sym_o = 9'd256 + {2'b00, p7};
      len_o = 4'd7;
    end else if (p8 <= 8'hBF) begin
      sym_o = {1'b0, p8 - 8'h30};
      len_o = 4'd8;
    end else if (p8 <= 8'hC7) begin
      sym_o = 9'd280 + {6'b0, p8[2:0]};
      len_o = 4'd8;
    end else begin
      // 0x190..0x1FF maps to literals 144..255, i.e. code - 256
      sym_o = peek_i - 9'd256;
      len_o = 4'd9;
    end
  end
endmodule

// File: rtl/huffman_fixed_dec.sv
// Fixed-Huffman DEFLATE decoder: byte-fed bit buffer, header/symbol FSM, literal/match token output.
module huffman_fixed_dec
  import huffman_fixed_pkg::*;
#(
  parameter int LIT_DAT_WD = LIT_DAT_W,
  parameter int LEN_DAT_WD = LEN_DAT_W,
  parameter int DIS_DAT_WD = DIS_DAT_W,
  parameter int BUF_WD     = BUF_W
) (
  input logic                clk,
  input logic                rstn,
  huffman_fixed_dec_if.slave bus
);
  localparam int CNT_W = $clog2(BUF_WD + 1);

  state_t                state_q, state_d;
  logic [BUF_WD-1:0]     buf_q, buf_d, buf_sh;
  logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_sh, n_cons;
  logic [2:0]            xcnt_q;
  logic                  err_q, final_q, eob_q, flg_lit_q;
  logic [LIT_DAT_WD-1:0] lit_q;
  logic [LEN_DAT_WD-1:0] len_q;
  logic [DIS_DAT_WD-1:0] dis_q;
  logic [8:0]            peek, sym;
  logic [3:0]            sym_len, xmask, xval;
  logic [4:0]            dcode, lidx;
  logic                  adv, accept;

  always_comb begin
    for (int i = 0; i < 9; i++) peek[8-i] = buf_q[i];
  end

  huffman_fixed_sym_dec u_sym (.peek_i(peek), .sym_o(sym), .len_o(sym_len));

  assign dcode = peek[8:4];
  assign lidx  = sym[4:0] - 5'd1;
  assign xmask = 4'((5'd1 << xcnt_q) - 5'd1);
  assign xval  = buf_q[3:0] & xmask;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_HDR;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    n_cons  = '0;
    adv     = 1'b0;
    case (state_q)
      ST_HDR: if (cnt_q >= CNT_W'(3)) begin
        adv = 1'b1;
        if (buf_q[2:1] == 2'b01) begin
          n_cons  = CNT_W'(3);
          state_d = ST_SYM;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_SYM: if (cnt_q >= CNT_W'(sym_len)) begin
        adv    = 1'b1;
        n_cons = CNT_W'(sym_len);
        if (sym < EOB_SYM)           state_d = ST_OUT;
        else if (sym == EOB_SYM)     state_d = final_q ? ST_DONE : ST_HDR;
        else if (sym <= LEN_SYM_LAST) state_d = ST_LEXT;
        else                         state_d = ST_DONE;
      end
      ST_LEXT: if (cnt_q >= CNT_W'(xcnt_q)) begin
        adv     = 1'b1;
        n_cons  = CNT_W'(xcnt_q);
        state_d = ST_DIS;
      end
      ST_DIS: if (cnt_q >= CNT_W'(5)) begin
        adv     = 1'b1;
        n_cons  = CNT_W'(5);
        state_d = (dcode <= DIS_CODE_LAST) ? ST_DEXT : ST_DONE;
      end
      ST_DEXT: if (cnt_q >= CNT_W'(xcnt_q)) begin
        adv     = 1'b1;
        n_cons  = CNT_W'(xcnt_q);
        state_d = ST_OUT;
      end
      ST_OUT:  if (bus.rdy_i) state_d = ST_SYM;
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_DONE;
    endcase
  end

  always_comb begin
    bus.val_o = (state_q == ST_OUT);
    bus.rdy_o = rstn && (cnt_q <= CNT_W'(BUF_WD - 8)) && !err_q && (state_q != ST_DONE);
  end

  // Consume is applied before the new byte is appended above the remaining bits.
  always_comb begin
    accept = bus.val_i && bus.rdy_o;
    buf_sh = buf_q >> n_cons;
    cnt_sh = cnt_q - n_cons;
    buf_d  = buf_sh;
    cnt_d  = cnt_sh;
    if (accept) begin
      buf_d = buf_sh | (BUF_WD'(bus.dat_i) << cnt_sh);
      cnt_d = cnt_sh + CNT_W'(8);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      buf_q     <= '0;
      cnt_q     <= '0;
      xcnt_q    <= '0;
      err_q     <= 1'b0;
      final_q   <= 1'b0;
      eob_q     <= 1'b0;
      flg_lit_q <= 1'b0;
      lit_q     <= '0;
      len_q     <= '0;
      dis_q     <= '0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
      eob_q <= 1'b0;
      if (adv) begin
        case (state_q)
          ST_HDR: begin
            final_q <= buf_q[0];
            if (buf_q[2:1] != 2'b01) err_q <= 1'b1;
          end
          ST_SYM: begin
            if (sym < EOB_SYM) begin
              flg_lit_q <= 1'b1;
              lit_q     <= LIT_DAT_WD'(sym[7:0]);
              len_q     <= '0;
              dis_q     <= '0;
            end else if (sym == EOB_SYM) begin
              eob_q <= 1'b1;
            end else if (sym <= LEN_SYM_LAST) begin
              flg_lit_q <= 1'b0;
              lit_q     <= '0;
              len_q     <= LEN_DAT_WD'(len_base(lidx));
              xcnt_q    <= len_xbits(lidx);
              dis_q     <= '0;
            end else begin
              err_q <= 1'b1;
            end
          end
          ST_LEXT: len_q <= len_q + LEN_DAT_WD'(xval);
          ST_DIS: begin
            if (dcode <= DIS_CODE_LAST) begin
              dis_q  <= DIS_DAT_WD'(dis_base(dcode[3:0]));
              xcnt_q <= dis_xbits(dcode[3:0]);
            end else begin
              err_q <= 1'b1;
            end
          end
          ST_DEXT: dis_q <= dis_q + DIS_DAT_WD'(xval);
          default: ;
        endcase
      end
    end
  end

  assign bus.flg_lit_o = flg_lit_q;
  assign bus.lit_dat_o = lit_q;
  assign bus.len_dat_o = len_q;
  assign bus.dis_dat_o = dis_q;
  assign bus.eob_o     = eob_q;
  assign bus.final_o   = final_q;
  assign bus.err_o     = err_q;

endmodule

// File: tb/tb_huffman_fixed_dec.sv
// Bench for huffman_fixed_dec: a bit-level fixed-Huffman encoder builds streams and the expected tokens.
module tb_huffman_fixed_dec;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  huffman_fixed_dec_if bus ();
  huffman_fixed_dec dut (.clk(clk), .rstn(rstn), .bus(bus));

  typedef struct {
    bit flg;
    int lit;
    int len;
    int dis;
  } tok_t;

  int         tests_run    = 0;
  int         tests_failed = 0;
  bit         bits_q[$];
  logic [7:0] bytes_q[$];
  tok_t       exp_q[$];
  int         exp_eobs;

  function automatic tok_t mk_tok(bit flg, int lit, int len, int dis);
    tok_t t;
    t.flg = flg; t.lit = lit; t.len = len; t.dis = dis;
    return t;
  endfunction

  function automatic logic [22:0] pack_tok(tok_t t);
    return {t.flg, 8'(t.lit), 7'(t.len), 7'(t.dis)};
  endfunction

  function automatic logic [22:0] dut_tok();
    return {bus.flg_lit_o, bus.lit_dat_o, bus.len_dat_o, bus.dis_dat_o};
  endfunction

  function automatic logic [27:0] outs_vec();
    return {bus.val_o, bus.rdy_o, bus.flg_lit_o, bus.lit_dat_o, bus.len_dat_o,
            bus.dis_dat_o, bus.eob_o, bus.final_o, bus.err_o};
  endfunction

  // ---------------- reference encoder ----------------
  task automatic enc_clear();
    bits_q.delete(); bytes_q.delete(); exp_q.delete(); exp_eobs = 0;
  endtask

  task automatic put_lsb(int v, int n);
    for (int i = 0; i < n; i++) bits_q.push_back(v[i]);
  endtask

  task automatic put_msb(int v, int n);
    for (int i = n - 1; i >= 0; i--) bits_q.push_back(v[i]);
  endtask

  task automatic enc_hdr(bit fin, int btype);
    put_lsb(int'(fin), 1);
    put_lsb(btype, 2);
  endtask

  task automatic enc_lit(int v);
    if (v < 144) put_msb(48 + v, 8);
    else         put_msb(400 + v - 144, 9);
    exp_q.push_back(mk_tok(1'b1, v, 0, 0));
  endtask

  task automatic enc_match(int l, int d);
    int sel, sbase, sxb, b, xb;
    sel = 0; sbase = 3; sxb = 0;
    for (int idx = 0; idx < 20; idx++) begin
      xb = (idx < 8) ? 0 : (idx - 4) / 4;
      b  = (idx < 8) ? 3 + idx : ((4 + idx % 4) << xb) + 3;
      if (b <= l) begin sel = idx; sbase = b; sxb = xb; end
    end
    put_msb(sel + 1, 7);
    put_lsb(l - sbase, sxb);
    sel = 0; sbase = 1; sxb = 0;
    for (int c = 0; c < 12; c++) begin
      xb = (c < 4) ? 0 : c / 2 - 1;
      b  = (c < 4) ? c + 1 : ((2 + c % 2) << xb) + 1;
      if (b <= d) begin sel = c; sbase = b; sxb = xb; end
    end
    put_msb(sel, 5);
    put_lsb(d - sbase, sxb);
    exp_q.push_back(mk_tok(1'b0, 0, l, d));
  endtask

  task automatic enc_eob();
    put_msb(0, 7);
    exp_eobs++;
  endtask

  task automatic enc_flush();
    logic [7:0] b;
    while (bits_q.size() % 8 != 0) bits_q.push_back(1'b0);
    for (int k = 0; k < bits_q.size(); k += 8) begin
      for (int j = 0; j < 8; j++) b[j] = bits_q[k + j];
      bytes_q.push_back(b);
    end
  endtask

  task automatic enc_rand_tok();
    if ($urandom_range(99) < 60) enc_lit(int'($urandom_range(255)));
    else enc_match(int'($urandom_range(66, 3)), int'($urandom_range(64, 1)));
  endtask

  // ---------------- drivers ----------------
  task automatic apply_reset();
    bus.val_i = 1'b0; bus.dat_i = 8'h00; bus.rdy_i = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_stream(string name, int val_pct, int rdy_pct, int stall_cyc);
    int tok_idx, eob_cnt, bidx, cyc, post, stall_left;
    logic [23:0] snap;
    bit snapped, stable_ok;
    tok_idx = 0; eob_cnt = 0; bidx = 0; cyc = 0; post = 0;
    stall_left = stall_cyc; snapped = 0; stable_ok = 1; snap = '0;
    while (cyc < 20000 && post < 6) begin
      @(negedge clk);
      cyc++;
      if (bus.eob_o) eob_cnt++;
      if (stall_left > 0 && (snapped || bus.val_o)) begin
        if (!snapped) begin snap = {bus.val_o, dut_tok()}; snapped = 1; end
        else if ({bus.val_o, dut_tok()} !== snap) stable_ok = 0;
        bus.rdy_i = 1'b0;
        stall_left--;
        if (stall_left == 0) begin
          tests_run++;
          if (!stable_ok) begin
            tests_failed++;
            $display("FAIL %s stall_stable: token changed while held, first %h now %h", name, snap, {bus.val_o, dut_tok()});
          end
          tests_run++;
          if (bus.rdy_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s stall_full: rdy_o=%b expected 0 with full buffer", name, bus.rdy_o);
          end
        end
      end else begin
        bus.rdy_i = ($urandom_range(99) < rdy_pct);
        if (bus.val_o && bus.rdy_i) begin
          tests_run++;
          if (tok_idx >= exp_q.size()) begin
            tests_failed++;
            $display("FAIL %s extra_token: got %h expected none", name, dut_tok());
          end else if (dut_tok() !== pack_tok(exp_q[tok_idx])) begin
            tests_failed++;
            $display("FAIL %s token[%0d]: got %h expected %h", name, tok_idx, dut_tok(), pack_tok(exp_q[tok_idx]));
          end
          tok_idx++;
        end
      end
      if (bidx < bytes_q.size()) begin
        bus.val_i = ($urandom_range(99) < val_pct);
        bus.dat_i = bytes_q[bidx];
        if (bus.val_i && bus.rdy_o) bidx++;
      end else begin
        bus.val_i = 1'b0;
      end
      if (tok_idx == exp_q.size() && eob_cnt == exp_eobs) post++;
    end
    tests_run++;
    if (cyc >= 20000) begin
      tests_failed++;
      $display("FAIL %s timeout: tokens %0d of %0d, eobs %0d of %0d", name, tok_idx, exp_q.size(), eob_cnt, exp_eobs);
    end
    tests_run++;
    if (eob_cnt != exp_eobs) begin
      tests_failed++;
      $display("FAIL %s eob_count: got %0d expected %0d", name, eob_cnt, exp_eobs);
    end
    tests_run++;
    if ({bus.val_o, bus.rdy_o, bus.final_o, bus.err_o} !== 4'b0010) begin
      tests_failed++;
      $display("FAIL %s end_state: val/rdy/final/err got %b expected 0010", name, {bus.val_o, bus.rdy_o, bus.final_o, bus.err_o});
    end
  endtask

  task automatic run_err(string name, int max_err_cyc);
    int first_err, bidx, rdy_err;
    bit seen_val;
    first_err = -1; bidx = 0; rdy_err = 0; seen_val = 0;
    bus.rdy_i = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (bus.val_o) seen_val = 1;
      if (bus.err_o && first_err < 0) first_err = cyc;
      if (bus.err_o && bus.rdy_o) rdy_err++;
      if (bidx < bytes_q.size()) begin
        bus.val_i = 1'b1;
        bus.dat_i = bytes_q[bidx];
        if (bus.rdy_o) bidx++;
      end else begin
        bus.val_i = 1'b0;
      end
    end
    tests_run++;
    if (first_err < 0 || first_err > max_err_cyc) begin
      tests_failed++;
      $display("FAIL %s err_time: err first seen at cycle %0d expected 1..%0d", name, first_err, max_err_cyc);
    end
    tests_run++;
    if (seen_val || rdy_err != 0 || bus.err_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s err_state: val_seen=%0b rdy_after_err=%0d err=%b expected 0/0/1", name, seen_val, rdy_err, bus.err_o);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #2 rstn = 1'b0;
    bus.val_i = 1'b0; bus.dat_i = 8'h00; bus.rdy_i = 1'b0;
    #1;
    tests_run++;
    if (outs_vec() !== 28'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h expected 0000000", outs_vec());
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    tests_run++;
    if (outs_vec() !== {1'b0, 1'b1, 26'h0}) begin
      tests_failed++;
      $display("FAIL reset_release: got %h expected %h", outs_vec(), {1'b0, 1'b1, 26'h0});
    end
  endtask

  task automatic test_literal_a();
    apply_reset();
    enc_clear();
    bytes_q = '{8'h73, 8'h04, 8'h00};
    exp_q.push_back(mk_tok(1'b1, 'h41, 0, 0));
    exp_eobs = 1;
    run_stream("literal_a", 100, 100, 0);
  endtask

  task automatic test_match_min();
    apply_reset();
    enc_clear();
    bytes_q = '{8'h03, 8'h02, 8'h00};
    exp_q.push_back(mk_tok(1'b0, 0, 3, 1));
    exp_eobs = 1;
    run_stream("match_min", 100, 100, 0);
  endtask

  task automatic test_boundaries();
    apply_reset();
    enc_clear();
    enc_hdr(1'b1, 1);
    enc_match(66, 64);
    enc_lit(143); enc_lit(144); enc_lit(255); enc_lit(0);
    enc_match(3, 1);
    enc_match(11, 5);
    enc_eob();
    enc_flush();
    run_stream("boundaries", 100, 100, 0);
  endtask

  task automatic test_errors();
    apply_reset();
    enc_clear();
    enc_hdr(1'b1, 2);
    enc_flush();
    run_err("btype10", 3);
    apply_reset();
    enc_clear();
    enc_hdr(1'b1, 1);
    put_msb('hC0, 8);
    put_msb(0, 16);
    enc_flush();
    run_err("sym280", 40);
    apply_reset();
    enc_clear();
    enc_hdr(1'b1, 1);
    put_msb(1, 7);
    put_msb(12, 5);
    put_msb(0, 16);
    enc_flush();
    run_err("dist12", 40);
  endtask

  task automatic test_back_pressure();
    apply_reset();
    enc_clear();
    enc_hdr(1'b1, 1);
    enc_match(10, 5);
    for (int i = 0; i < 12; i++) enc_lit(int'($urandom_range(255)));
    enc_eob();
    enc_flush();
    run_stream("back_pressure", 100, 100, 10);
  endtask

  task automatic test_reset_mid_match();
    int cyc;
    apply_reset();
    bus.rdy_i = 1'b0;
    bytes_q = '{8'h03, 8'h02, 8'h00};
    cyc = 0;
    for (int k = 0; k < 3; k++) begin
      bus.val_i = 1'b1;
      bus.dat_i = bytes_q[k];
      @(negedge clk);
    end
    bus.val_i = 1'b0;
    while (!bus.val_o && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    tests_run++;
    if (bus.val_o !== 1'b1 || bus.len_dat_o !== 7'd3) begin
      tests_failed++;
      $display("FAIL mid_reset_pre: val=%b len=%0d expected 1/3", bus.val_o, bus.len_dat_o);
    end
    #2 rstn = 1'b0;
    #1;
    tests_run++;
    if (outs_vec() !== 28'h0) begin
      tests_failed++;
      $display("FAIL mid_reset_outputs: got %h expected 0000000", outs_vec());
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    enc_clear();
    bytes_q = '{8'h73, 8'h04, 8'h00};
    exp_q.push_back(mk_tok(1'b1, 'h41, 0, 0));
    exp_eobs = 1;
    run_stream("after_mid_reset", 100, 100, 0);
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 4; it++) begin
      apply_reset();
      enc_clear();
      enc_hdr(1'b0, 1);
      n = int'($urandom_range(25, 5));
      for (int i = 0; i < n; i++) enc_rand_tok();
      enc_eob();
      enc_hdr(1'b1, 1);
      n = int'($urandom_range(25, 5));
      for (int i = 0; i < n; i++) enc_rand_tok();
      enc_eob();
      enc_flush();
      run_stream("random", int'($urandom_range(100, 30)), int'($urandom_range(100, 30)), 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_literal_a();
    test_match_min();
    test_boundaries();
    test_errors();
    test_back_pressure();
    test_reset_mid_match();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
